// File: rtl/mem_wb_stage_pkg.sv
// Shared CPU pipeline package: default widths and the MEM/WB pipeline entry layout.
// Used by mem_wb_stage and anything else that needs to carry a writeback entry.
package mem_wb_stage_pkg;

    localparam int DEF_XLEN       = 32;
    localparam int DEF_REG_ADDR_W = 5;

    typedef struct packed {
        logic                      valid;
        logic                      wr;
        logic [DEF_REG_ADDR_W-1:0] addr;
        logic [DEF_XLEN-1:0]       data;
    } mem_wb_entry_t;

    // Only a clean load returns memory data; a store, an illegal load+store and an ALU op use the bypass.
    function automatic logic wb_sel_load(input logic read_en, input logic write_en);
        return read_en & ~write_en;
    endfunction

endpackage

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with an RF write strobe, a forwarding tap and a sticky load+store error flag.
// Latency: one cycle from capture to outputs. Backpressure: stall holds the entry and masks the RF strobe.
// Optional MEM_WB_RETIRE_CNT_EN adds a 64-bit retire_count output.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  dm_read_enable,
    input  logic                  dm_write_enable,
    input  logic [XLEN-1:0]       dm_read_data,
    input  logic [XLEN-1:0]       dm_data_bypass,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  rd_write_enable,
    input  logic                  err_clear,
    output logic                  rf_write_enable,
    output logic [REG_ADDR_W-1:0] rf_write_addr,
    output logic [XLEN-1:0]       rf_write_data,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_addr,
    output logic [XLEN-1:0]       fwd_data,
    output logic                  access_error
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [63:0]           retire_count
`endif
);

    mem_wb_entry_t   r_entry;
    logic            r_access_error;

    logic            w_both_en;
    logic            w_wr;
    logic            w_capture;
    logic            w_err_set;
    logic [XLEN-1:0] w_wb_data;
    logic            w_fwd_vld;

    assign w_both_en = dm_read_enable & dm_write_enable;
    assign w_wb_data = wb_sel_load(dm_read_enable, dm_write_enable) ? dm_read_data : dm_data_bypass;
    assign w_wr      = in_valid & rd_write_enable & ~dm_write_enable & ~w_both_en & (rd_addr != '0);
    assign w_capture = ~flush & ~stall;
    assign w_err_set = w_capture & in_valid & w_both_en;

    // Flush only kills valid; the stale fields are harmless because valid gates every consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry <= '0;
        end else if (flush) begin
            r_entry.valid <= 1'b0;
        end else if (!stall) begin
            r_entry <= '{valid: in_valid, wr: w_wr, addr: rd_addr, data: w_wb_data};
        end
    end

    // Set wins over a same-cycle clear so an error is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_access_error <= 1'b0;
        end else begin
            r_access_error <= w_err_set | (r_access_error & ~err_clear);
        end
    end

    assign w_fwd_vld       = r_entry.valid & r_entry.wr;
    assign rf_write_enable = w_fwd_vld & ~stall;
    assign rf_write_addr   = r_entry.addr;
    assign rf_write_data   = r_entry.data;
    assign fwd_valid       = w_fwd_vld;
    assign fwd_addr        = r_entry.addr;
    assign fwd_data        = r_entry.data;
    assign access_error    = r_access_error;

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [63:0] r_retire_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (r_entry.valid && !stall) begin
            r_retire_cnt <= r_retire_cnt + 64'd1;
        end
    end

    assign retire_count = r_retire_cnt;
`endif

endmodule
